// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_core
//  Purpose  : Multi-cycle MIPS subset core (add/sub/and/or/slt, addi, lw, sw,
//             beq, j). The FSM steps through FETCH, DECODE, EXECUTE, MEMORY
//             and WRITEBACK. The ALU, register file and sign-extend are
//             shared across those steps. Instruction and data memories sit
//             behind req/ready handshakes, so they may insert wait states.
//  Options  : define MIPS_BNE_EN to decode bne (opcode 000101). When it is
//             not defined, bne is treated as an illegal opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_core #(
   parameter int          ADDR_WIDTH = 16,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          REG_COUNT  = 32
) (
   input  logic                  CLK,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic                  imem_req,
   input  logic [31:0]           imem_rdata,
   input  logic                  imem_ready,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [31:0]           dmem_wdata,
   output logic                  dmem_we,
   output logic                  dmem_req,
   input  logic [31:0]           dmem_rdata,
   input  logic                  dmem_ready,
   input  logic [4:0]            dbg_reg_addr,
   output logic [31:0]           dbg_reg_data,
   output logic [31:0]           retired_count,
   output logic                  halted
);

   localparam int REG_BITS = $clog2(REG_COUNT);

   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_EXECUTE   = 3'd2;
   localparam logic [2:0] ST_MEMORY    = 3'd3;
   localparam logic [2:0] ST_WRITEBACK = 3'd4;
   localparam logic [2:0] ST_HALT      = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

`ifdef MIPS_BNE_EN
   localparam logic BNE_EN = 1'b1;
`else
   localparam logic BNE_EN = 1'b0;
`endif

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [31:0]           ir;
   logic [31:0]           op_a;
   logic [31:0]           op_b;
   logic [31:0]           imm;
   logic [31:0]           alu_out;
   logic [31:0]           mdr;
   logic [31:0]           regs [REG_COUNT];

   // Instruction fields; specifier bits above REG_BITS are dropped
   logic [5:0]            opcode;
   logic [5:0]            funct;
   logic [REG_BITS-1:0]   rs_idx;
   logic [REG_BITS-1:0]   rt_idx;
   logic [REG_BITS-1:0]   rd_idx;
   logic [REG_BITS-1:0]   wb_idx;
   logic [REG_BITS-1:0]   dbg_idx;
   logic [31:0]           wb_data;
   logic                  wb_en;
   logic [31:0]           alu_result;
   logic                  rtype_legal;
   logic [31:0]           addr_sum;
   logic [ADDR_WIDTH-1:0] br_target;
   logic [ADDR_WIDTH-1:0] jump_target;
   logic                  unused_bits;

   assign opcode  = ir[31:26];
   assign funct   = ir[5:0];
   assign rs_idx  = ir[21 +: REG_BITS];
   assign rt_idx  = ir[16 +: REG_BITS];
   assign rd_idx  = ir[11 +: REG_BITS];
   assign dbg_idx = dbg_reg_addr[REG_BITS-1:0];

   // shamt and the high specifier bits have no function in this subset
   assign unused_bits = ^{ir[25:6], dbg_reg_addr};

   // R-type result and legality, decoded from funct
   always_comb begin
      alu_result  = 32'h0;
      rtype_legal = 1'b1;
      case (funct)
         FN_ADD:  alu_result = op_a + op_b;
         FN_SUB:  alu_result = op_a - op_b;
         FN_AND:  alu_result = op_a & op_b;
         FN_OR:   alu_result = op_a | op_b;
         FN_SLT:  alu_result = {31'h0, $signed(op_a) < $signed(op_b)};
         default: rtype_legal = 1'b0;
      endcase
   end

   // Address arithmetic; the PC already points past the current instruction
   assign addr_sum    = op_a + imm;
   assign br_target   = pc + ADDR_WIDTH'(imm << 2);
   assign jump_target = ADDR_WIDTH'({4'(32'(pc) >> 28), ir[25:0], 2'b00});

   // Destination is rd for R-type and rt for addi/lw; $0 is never written
   assign wb_idx  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
   assign wb_data = (opcode == OP_LW) ? mdr : alu_out;
   assign wb_en   = (state == ST_WRITEBACK) && (wb_idx != '0);

   // Memory-side outputs decode straight from the state so reset drops them
   assign imem_req     = (state == ST_FETCH);
   assign imem_addr    = pc;
   assign dmem_req     = (state == ST_MEMORY);
   assign dmem_we      = (state == ST_MEMORY) && (opcode == OP_SW);
   assign dmem_addr    = alu_out[ADDR_WIDTH-1:0];
   assign dmem_wdata   = op_b;
   assign halted       = (state == ST_HALT);
   assign dbg_reg_data = (dbg_idx == '0) ? 32'h0 : regs[dbg_idx];

   // Register file: cleared on reset, single write port used in WRITEBACK
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= 32'h0;
         end
      end else if (wb_en) begin
         regs[wb_idx] <= wb_data;
      end
   end

   // Control FSM with PC, IR, operand latches and the retire counter
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state         <= ST_FETCH;
         pc            <= ADDR_WIDTH'(RESET_PC);
         ir            <= 32'h0;
         op_a          <= 32'h0;
         op_b          <= 32'h0;
         imm           <= 32'h0;
         alu_out       <= 32'h0;
         mdr           <= 32'h0;
         retired_count <= 32'h0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (imem_ready) begin
                  ir    <= imem_rdata;
                  pc    <= pc + ADDR_WIDTH'(4);
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               op_a  <= regs[rs_idx];
               op_b  <= regs[rt_idx];
               imm   <= {{16{ir[15]}}, ir[15:0]};
               state <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               case (opcode)
                  OP_RTYPE: begin
                     if (rtype_legal) begin
                        alu_out <= alu_result;
                        state   <= ST_WRITEBACK;
                     end else begin
                        state <= ST_HALT;
                     end
                  end
                  OP_ADDI: begin
                     alu_out <= addr_sum;
                     state   <= ST_WRITEBACK;
                  end
                  OP_LW, OP_SW: begin
                     alu_out <= addr_sum;
                     state   <= ST_MEMORY;
                  end
                  OP_BEQ: begin
                     if (op_a == op_b) begin
                        pc <= br_target;
                     end
                     retired_count <= retired_count + 32'd1;
                     state         <= ST_FETCH;
                  end
                  OP_BNE: begin
                     if (BNE_EN) begin
                        if (op_a != op_b) begin
                           pc <= br_target;
                        end
                        retired_count <= retired_count + 32'd1;
                        state         <= ST_FETCH;
                     end else begin
                        state <= ST_HALT;
                     end
                  end
                  OP_J: begin
                     pc            <= jump_target;
                     retired_count <= retired_count + 32'd1;
                     state         <= ST_FETCH;
                  end
                  default: state <= ST_HALT;
               endcase
            end
            ST_MEMORY: begin
               if (dmem_ready) begin
                  if (opcode == OP_SW) begin
                     retired_count <= retired_count + 32'd1;
                     state         <= ST_FETCH;
                  end else begin
                     mdr   <= dmem_rdata;
                     state <= ST_WRITEBACK;
                  end
               end
            end
            ST_WRITEBACK: begin
               retired_count <= retired_count + 32'd1;
               state         <= ST_FETCH;
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_HALT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_multicycle_core
//  Purpose  : Directed programs for mips_multicycle_core. Expected fetch and
//             data accesses are queued up front and a monitor compares them
//             against the handshakes the core presents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_core;

   localparam int AW = 16;

   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] imem_addr;
   logic          imem_req;
   logic [31:0]   imem_rdata;
   logic          imem_ready;
   logic [AW-1:0] dmem_addr;
   logic [31:0]   dmem_wdata;
   logic          dmem_we;
   logic          dmem_req;
   logic [31:0]   dmem_rdata;
   logic          dmem_ready;
   logic [4:0]    dbg_reg_addr = 5'd0;
   logic [31:0]   dbg_reg_data;
   logic [31:0]   retired_count;
   logic          halted;

   int tests = 0;
   int fails = 0;

   mips_multicycle_core #(.ADDR_WIDTH(AW), .RESET_PC(32'h0), .REG_COUNT(32)) dut (
      .CLK(CLK), .reset(reset),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_req(dmem_req),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
      .retired_count(retired_count), .halted(halted)
   );

   always #5 CLK = ~CLK;

   // Memory models: zero-wait instruction side, programmable waits on data side
   logic [31:0] imem [0:16383];
   logic [31:0] dmem [0:63];
   int          dmem_waits = 0;
   int          dwait_cnt;

   assign imem_ready = imem_req;
   assign imem_rdata = imem[imem_addr[15:2]];
   assign dmem_ready = dmem_req && (dwait_cnt >= dmem_waits);
   assign dmem_rdata = dmem[dmem_addr[7:2]];

   always @(posedge CLK or posedge reset) begin
      if (reset) dwait_cnt <= 0;
      else if (!dmem_req || dmem_ready) dwait_cnt <= 0;
      else dwait_cnt <= dwait_cnt + 1;
   end

   always @(posedge CLK) begin
      if (!reset && dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
   end

   // Scoreboard queues
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } dreq_t;

   int    fetch_q[$];
   dreq_t dmem_q[$];
   int    mon_faddr;
   dreq_t mon_d;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Monitor: compare every accepted fetch / data access with the queues
   always @(negedge CLK) begin
      if (!reset) begin
         if (imem_req && imem_ready) begin
            if (fetch_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL fetch_unexpected: got addr %h, expected no fetch", imem_addr);
            end else begin
               mon_faddr = fetch_q.pop_front();
               check("fetch_addr", 32'(imem_addr), mon_faddr);
            end
         end
         if (dmem_req && dmem_ready) begin
            if (dmem_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL dmem_unexpected: got addr %h, expected no access", dmem_addr);
            end else begin
               mon_d = dmem_q.pop_front();
               check("dmem_addr", 32'(dmem_addr), mon_d.addr);
               check("dmem_we", 32'(dmem_we), 32'(mon_d.we));
               if (mon_d.we) check("dmem_wdata", dmem_wdata, mon_d.wdata);
            end
         end
      end
   end

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int im);
      return {op, 5'(rs), 5'(rt), 16'(im)};
   endfunction

   function automatic logic [31:0] enc_j(input int target);
      return {6'b000010, 26'(target)};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 16384; i++) imem[i] = 32'hFFFF_FFFF;
   endtask

   task automatic put(input int addr, input logic [31:0] w);
      imem[addr >> 2] = w;
   endtask

   task automatic apply_reset(input bit chk);
      reset = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      if (chk) begin
         check("rst_imem_addr", 32'(imem_addr), 32'h0);
         check("rst_imem_req", 32'(imem_req), 32'h1);
         check("rst_dmem_req", 32'(dmem_req), 32'h0);
         check("rst_dmem_we", 32'(dmem_we), 32'h0);
         check("rst_retired", retired_count, 32'h0);
         check("rst_halted", 32'(halted), 32'h0);
         dbg_reg_addr = 5'd3;
         #1 check("rst_reg3", dbg_reg_data, 32'h0);
      end
      @(posedge CLK);
      #1 reset = 1'b0;
   endtask

   task automatic wait_retire(output int cycles);
      logic [31:0] start;
      start  = retired_count;
      cycles = 0;
      do begin
         @(posedge CLK);
         #1;
         cycles++;
      end while (retired_count == start && cycles < 60);
      if (retired_count == start) begin
         tests++; fails++;
         $display("FAIL retire_timeout: got no retirement in %0d cycles, expected one", cycles);
      end
   endtask

   task automatic check_lat(input string name, input int exp);
      int c;
      wait_retire(c);
      check(name, c, exp);
   endtask

   task automatic wait_halt(input string name);
      int c;
      c = 0;
      while (!halted && c < 100) begin
         @(posedge CLK);
         #1;
         c++;
      end
      check(name, 32'(halted), 32'h1);
   endtask

   task automatic check_reg(input string name, input int r, input logic [31:0] exp);
      dbg_reg_addr = 5'(r);
      #1 check(name, dbg_reg_data, exp);
   endtask

   initial begin
      // ---------------- straight-line ALU ----------------
      clear_imem();
      put('h00, enc_i(OP_ADDI, 0, 1, 5));
      put('h04, enc_i(OP_ADDI, 0, 2, 7));
      put('h08, enc_r(1, 2, 3, FN_ADD));
      put('h0C, enc_r(1, 2, 4, FN_SUB));
      put('h10, enc_r(1, 2, 5, FN_SLT));
      fetch_q = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14};
      dmem_waits = 0;
      apply_reset(1'b1);
      repeat (20) @(posedge CLK);
      #1 check("alu_retired_20", retired_count, 32'd5);
      check("alu_not_halted_yet", 32'(halted), 32'h0);
      repeat (3) @(posedge CLK);
      #1 check("illegal_halted_3", 32'(halted), 32'h1);
      check("halt_imem_req", 32'(imem_req), 32'h0);
      repeat (5) @(posedge CLK);
      #1 check("halt_retired_frozen", retired_count, 32'd5);
      check("halt_imem_req_late", 32'(imem_req), 32'h0);
      check_reg("alu_r3", 3, 32'd12);
      check_reg("alu_r4", 4, 32'hFFFF_FFFE);
      check_reg("alu_r5", 5, 32'd1);
      check("alu_fetchq_empty", fetch_q.size(), 0);

      // ---------------- load/store, 2 data wait states ----------------
      clear_imem();
      put('h00, enc_i(OP_ADDI, 0, 3, 12));
      put('h04, enc_i(OP_SW, 0, 3, 8));
      put('h08, enc_i(OP_LW, 0, 6, 8));
      fetch_q = '{'h00, 'h04, 'h08, 'h0C};
      dmem_q.push_back('{32'd8, 1'b1, 32'd12});
      dmem_q.push_back('{32'd8, 1'b0, 32'd0});
      dmem_waits = 2;
      apply_reset(1'b1);
      check_lat("ls_addi_lat", 4);
      check_lat("ls_sw_lat", 6);
      check_lat("ls_lw_lat", 7);
      wait_halt("ls_halted");
      check_reg("ls_r6", 6, 32'd12);
      check("ls_fetchq_empty", fetch_q.size(), 0);
      check("ls_dmemq_empty", dmem_q.size(), 0);

      // ---------------- control flow ----------------
      clear_imem();
      put('h00, enc_i(OP_ADDI, 0, 1, 3));
      put('h04, enc_i(OP_ADDI, 0, 2, 4));
      put('h08, enc_i(OP_BEQ, 1, 2, 5));
      put('h0C, enc_i(OP_ADDI, 0, 8, 1));
      put('h10, enc_i(OP_BEQ, 1, 1, 2));
      put('h14, enc_i(OP_ADDI, 0, 9, 99));
      put('h18, enc_i(OP_ADDI, 0, 9, 98));
      put('h1C, enc_j('h40));
      put('h100, enc_i(OP_ADDI, 0, 10, 'h55));
      fetch_q = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h1C, 'h100, 'h104};
      dmem_waits = 0;
      apply_reset(1'b0);
      check_lat("cf_addi1_lat", 4);
      check_lat("cf_addi2_lat", 4);
      check_lat("cf_beq_ne_lat", 3);
      check_lat("cf_addi8_lat", 4);
      check_lat("cf_beq_eq_lat", 3);
      check_lat("cf_j_lat", 3);
      check_lat("cf_addi10_lat", 4);
      wait_halt("cf_halted");
      check("cf_retired", retired_count, 32'd7);
      check_reg("cf_r8", 8, 32'd1);
      check_reg("cf_r9", 9, 32'd0);
      check_reg("cf_r10", 10, 32'h55);
      check("cf_fetchq_empty", fetch_q.size(), 0);

      // ---------------- register 0, arithmetic and PC wrap ----------------
      clear_imem();
      put('h00, enc_i(OP_BEQ, 11, 0, 3));
      put('h10, enc_i(OP_ADDI, 0, 0, 9));
      put('h14, enc_i(OP_ADDI, 0, 7, -1));
      put('h18, enc_i(OP_ADDI, 7, 7, 1));
      put('h1C, enc_j('h3FFF));
      put('hFFFC, enc_i(OP_ADDI, 11, 11, 1));
      fetch_q = '{'h00, 'h10, 'h14, 'h18, 'h1C, 'hFFFC, 'h00, 'h04};
      apply_reset(1'b0);
      wait_halt("wr_halted");
      check("wr_retired", retired_count, 32'd7);
      check_reg("wr_r0", 0, 32'd0);
      check_reg("wr_r7", 7, 32'd0);
      check_reg("wr_r11", 11, 32'd1);
      check("wr_fetchq_empty", fetch_q.size(), 0);

      // ---------------- reset during MEMORY ----------------
      clear_imem();
      put('h00, enc_i(OP_LW, 0, 6, 8));
      fetch_q = '{'h00};
      dmem_waits = 5;
      apply_reset(1'b0);
      begin
         int c;
         c = 0;
         while (!dmem_req && c < 20) begin
            @(posedge CLK);
            #1;
            c++;
         end
      end
      check("mr_dmem_req_seen", 32'(dmem_req), 32'h1);
      @(posedge CLK);
      #1 check("mr_dmem_req_wait", 32'(dmem_req), 32'h1);
      #1 reset = 1'b1;
      #1 check("mr_dmem_req_dropped", 32'(dmem_req), 32'h0);
      check("mr_dmem_we_dropped", 32'(dmem_we), 32'h0);
      @(posedge CLK);
      #1 reset = 1'b0;
      #1 check("mr_imem_addr", 32'(imem_addr), 32'h0);
      check("mr_imem_req", 32'(imem_req), 32'h1);
      check("mr_halted", 32'(halted), 32'h0);
      check("mr_retired", retired_count, 32'h0);
      #1 reset = 1'b1;
      check("mr_fetchq_empty", fetch_q.size(), 0);

      // ---------------- bne ----------------
      clear_imem();
      put('h00, enc_i(OP_ADDI, 0, 1, 1));
      put('h04, enc_i(OP_ADDI, 0, 2, 2));
      put('h08, enc_i(OP_BNE, 1, 2, 1));
      put('h0C, enc_i(OP_ADDI, 0, 13, 7));
      put('h10, enc_i(OP_ADDI, 0, 14, 9));
      dmem_waits = 0;
`ifdef MIPS_BNE_EN
      fetch_q = '{'h00, 'h04, 'h08, 'h10, 'h14};
      apply_reset(1'b0);
      check_lat("bne_addi1_lat", 4);
      check_lat("bne_addi2_lat", 4);
      check_lat("bne_taken_lat", 3);
      check_lat("bne_addi14_lat", 4);
      wait_halt("bne_halted");
      check("bne_retired", retired_count, 32'd4);
      check_reg("bne_r13", 13, 32'd0);
      check_reg("bne_r14", 14, 32'd9);
`else
      fetch_q = '{'h00, 'h04, 'h08};
      apply_reset(1'b0);
      check_lat("bne_addi1_lat", 4);
      check_lat("bne_addi2_lat", 4);
      wait_halt("bne_illegal_halted");
      check("bne_retired", retired_count, 32'd2);
`endif
      check("bne_fetchq_empty", fetch_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by time limit, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
